sigdel_decimator: RTL

SIGDEL_DECIMATOR -- requirements
Module: sigdel_decimator

---
 rtl/sigdel_pkg.sv | 13 +
 rtl/cic_integrator.sv | 25 ++
 rtl/sigdel_decimator.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sigdel_pkg.sv
// Shared constants and width helper for the sigma-delta CIC decimator.
package sigdel_pkg;

    localparam int unsigned CIC_ORDER     = 3;
    localparam int unsigned OUT_W         = 16;
    localparam int unsigned DECIM_DEFAULT = 64;

    // Bit growth of an order-N CIC with unit differential delay, plus the input sign bit.
    function automatic int unsigned cic_width(input int unsigned decim);
        return CIC_ORDER * $clog2(decim) + 1;
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: wrap-around W-bit accumulator that advances only when enabled.
module cic_integrator #(
    parameter int unsigned W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum
);

    logic [W-1:0] acc_q;

    // Updated value is exposed so the next stage sees it within the same accepted bit.
    assign sum = acc_q + din;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/sigdel_decimator.sv
// 3rd-order CIC decimator turning a 1-bit sigma-delta stream into 16-bit signed PCM.
// Build option SIGDEL_DEC_SAT_EN: saturate the scaled result instead of truncating it.
module sigdel_decimator
    import sigdel_pkg::*;
#(
    parameter int unsigned DECIM = DECIM_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic signed [OUT_W-1:0] out_sample,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    localparam int unsigned W     = cic_width(DECIM);
    localparam int unsigned PW    = $clog2(DECIM);
    localparam int unsigned SHIFT = W - OUT_W;

    if (DECIM != 32 && DECIM != 64 && DECIM != 128) begin : g_bad_decim
        $error("sigdel_decimator: DECIM must be 32, 64 or 128");
    end

    // ---------------------------------------------------------------- integrators
    logic [PW-1:0]                phase_q;
    logic                         tick;
    logic [CIC_ORDER:0][W-1:0]    isum;

    assign tick    = bit_valid && (phase_q == PW'(DECIM - 1));
    assign isum[0] = bit_in ? W'(1) : {W{1'b1}};

    for (genvar g = 0; g < CIC_ORDER; g++) begin : g_int
        cic_integrator #(
            .W (W)
        ) u_int (
            .clk (clk),
            .rst (rst),
            .en  (bit_valid),
            .din (isum[g]),
            .sum (isum[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
        end else if (bit_valid) begin
            phase_q <= phase_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------- combs
    logic [W-1:0] c0, c1, c2, c3;
    logic [W-1:0] d0_q, d1_q, d2_q;
    logic [W-1:0] comb_q;
    logic         load_q;

    assign c0 = isum[CIC_ORDER];
    assign c1 = c0 - d0_q;
    assign c2 = c1 - d1_q;
    assign c3 = c2 - d2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d0_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            comb_q <= '0;
            load_q <= 1'b0;
        end else begin
            load_q <= tick;
            if (tick) begin
                d0_q   <= c0;
                d1_q   <= c1;
                d2_q   <= c2;
                comb_q <= c3;
            end
        end
    end

    // ---------------------------------------------------------------- scaling
    logic [OUT_W-1:0] scaled;

`ifdef SIGDEL_DEC_SAT_EN
    localparam logic [W-1:0]   WMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W:0] SMAX = {{(W-OUT_W+1){1'b0}}, 1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [W:0] SMIN = {{(W-OUT_W+1){1'b1}}, 1'b1, {(OUT_W-1){1'b0}}};

    logic              last_bit_q;
    logic signed [W:0] wide;
    logic signed [W:0] shifted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_bit_q <= 1'b0;
        end else if (tick) begin
            last_bit_q <= bit_in;
        end
    end

    // Full-scale +2^(W-1) aliases to the most negative W-bit code; the newest bit has
    // nonzero weight in every output, so it tells all-ones from all-zeros.
    always_comb begin
        wide = $signed({comb_q[W-1], comb_q});
        if (comb_q == WMIN && last_bit_q) begin
            wide = $signed({1'b0, comb_q});
        end
        shifted = wide >>> SHIFT;
        if (shifted > SMAX) begin
            scaled = SMAX[OUT_W-1:0];
        end else if (shifted < SMIN) begin
            scaled = SMIN[OUT_W-1:0];
        end else begin
            scaled = shifted[OUT_W-1:0];
        end
    end
`else
    logic unused_comb_lsbs;

    // Arithmetic shift by W-16 then truncation keeps exactly the top 16 bits.
    assign scaled           = comb_q[W-1 -: OUT_W];
    assign unused_comb_lsbs = ^comb_q;
`endif

    // ---------------------------------------------------------------- output register
    logic [OUT_W-1:0] out_sample_q;
    logic             out_valid_q;
    logic             overrun_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= load_q && out_valid_q && !out_ready;
            if (load_q) begin
                out_sample_q <= scaled;
                out_valid_q  <= 1'b1;
            end else if (out_ready) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;

endmodule
